// File: rtl/ariane_pkg.sv
// Shared frontend types used by the BHT update scheduler.
// Holds the BHT update bundle, fetch width and scheduler state enum.
package ariane_pkg;

    localparam int unsigned VLEN            = 64;
    localparam int unsigned INSTR_PER_FETCH = 2;

    typedef struct packed {
        logic            valid;
        logic [VLEN-1:0] pc;
        logic            taken;
    } bht_update_t;

    typedef enum logic [1:0] {
        INIT,
        FLUSH,
        RUN
    } bht_sched_state_e;

endpackage

// File: rtl/fifo_v3.sv
// Synchronous FIFO with optional fall-through and synchronous flush.
// Ports: clk_i, rst_ni, flush_i, full_o, empty_o, data_i/push_i, data_o/pop_i.
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  empty_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);

    logic [AW-1:0]         rd_ptr, wr_ptr;
    logic [AW:0]           cnt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  do_push, do_pop, bypass;

    assign full_o  = (cnt == (AW+1)'(DEPTH));
    assign empty_o = (cnt == '0) && !(FALL_THROUGH && push_i);
    assign data_o  = (FALL_THROUGH && cnt == '0) ? data_i : mem[rd_ptr];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    // fall-through word consumed in the same cycle never touches storage
    assign bypass  = FALL_THROUGH && (cnt == '0) && do_push && do_pop;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (!bypass) begin
            if (do_push) begin
                mem[wr_ptr] <= data_i;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop) cnt <= cnt + (AW+1)'(1);
            else if (!do_push && do_pop) cnt <= cnt - (AW+1)'(1);
        end
    end

endmodule

// File: rtl/bht_update_sched.sv
// BHT update scheduler: round-robin requester arbitration into a FIFO,
// one update per cycle to the BHT, and a row-by-row table clear sequencer.
// Ports: clk_i, rst_ni, flush_i, debug_mode_i, req_valid_i/req_update_i,
// req_ready_o, bht_update_o/bht_ready_i, clr_we_o/clr_addr_o, busy_o.
module bht_update_sched
    import ariane_pkg::*;
#(
    parameter int unsigned NR_ENTRIES = 1024,
    parameter int unsigned NR_REQ     = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     debug_mode_i,
    input  logic        [NR_REQ-1:0] req_valid_i,
    input  bht_update_t [NR_REQ-1:0] req_update_i,
    output logic        [NR_REQ-1:0] req_ready_o,
    output bht_update_t              bht_update_o,
    input  logic                     bht_ready_i,
    output logic                     clr_we_o,
    output logic [$clog2(NR_ENTRIES/INSTR_PER_FETCH)-1:0] clr_addr_o,
    output logic                     busy_o
);

    localparam int unsigned NR_ROWS = NR_ENTRIES / INSTR_PER_FETCH;
    localparam int unsigned RW      = $clog2(NR_ROWS);
    localparam int unsigned QW      = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

    bht_sched_state_e state_q, state_d;
    logic [RW-1:0]    row_q, row_d;
    logic [QW-1:0]    rr_q, rr_d;
    logic [NR_REQ-1:0] grant;
    logic             found, flush_fifo;
    logic             fifo_full, fifo_empty;
    logic             push, pop, out_valid;
    bht_update_t      push_data, head;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= INIT;
            row_q   <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            rr_q    <= rr_d;
        end
    end

    always_comb begin
        int unsigned idx;
        state_d    = state_q;
        row_d      = row_q;
        rr_d       = rr_q;
        grant      = '0;
        found      = 1'b0;
        flush_fifo = 1'b0;
        idx        = 0;
        unique case (state_q)
            INIT: state_d = FLUSH;
            FLUSH: begin
                if (flush_i) begin
                    row_d = '0;
                end else if (row_q == RW'(NR_ROWS - 1)) begin
                    row_d   = '0;
                    state_d = RUN;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end
            RUN: begin
                if (flush_i) begin
                    state_d    = FLUSH;
                    row_d      = '0;
                    flush_fifo = 1'b1;
                end else if (!fifo_full) begin
                    // first valid requester at or after rr_q, wrapping
                    for (int i = 0; i < int'(NR_REQ); i++) begin
                        idx = (int'(rr_q) + i) % NR_REQ;
                        if (!found && req_valid_i[idx]) begin
                            found      = 1'b1;
                            grant[idx] = 1'b1;
                            rr_d       = QW'((idx + 1) % NR_REQ);
                        end
                    end
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_comb begin
        push_data = '0;
        for (int k = 0; k < int'(NR_REQ); k++) begin
            if (grant[k]) push_data = req_update_i[k];
        end
        push_data.valid = 1'b1;
    end

    // debug-mode updates are handshaken but never stored
    assign push      = (|grant) && !debug_mode_i;
    assign out_valid = !fifo_empty && (state_q == RUN);
    assign pop       = out_valid && bht_ready_i;

    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DATA_WIDTH   ($bits(bht_update_t)),
        .DEPTH        (FIFO_DEPTH)
    ) i_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_fifo),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .data_i  (push_data),
        .push_i  (push),
        .data_o  (head),
        .pop_i   (pop)
    );

    always_comb begin
        bht_update_o = '0;
        if (out_valid) begin
            bht_update_o       = head;
            bht_update_o.valid = 1'b1;
        end
    end

    assign req_ready_o = grant;
    assign clr_we_o    = (state_q == FLUSH);
    assign clr_addr_o  = row_q;
    assign busy_o      = (state_q != RUN);

endmodule

// File: tb/tb_bht_update_sched.sv
// Directed bench for bht_update_sched with a queue-based reference model.
// Checks every cycle against the model plus hand-computed milestones.
module tb_bht_update_sched;
    import ariane_pkg::*;

    localparam int NROWS = 512;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic              dbg = 1'b0;
    logic        [1:0] rv = '0;
    bht_update_t [1:0] ru;
    logic        [1:0] rr;
    bht_update_t       uo;
    logic              bready = 1'b0;
    logic              clr_we;
    logic        [8:0] clr_addr;
    logic              busy;

    always #5 clk = ~clk;

    bht_update_sched #(
        .NR_ENTRIES (1024),
        .NR_REQ     (2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .flush_i      (flush),
        .debug_mode_i (dbg),
        .req_valid_i  (rv),
        .req_update_i (ru),
        .req_ready_o  (rr),
        .bht_update_o (uo),
        .bht_ready_i  (bready),
        .clr_we_o     (clr_we),
        .clr_addr_o   (clr_addr),
        .busy_o       (busy)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // reference model: pending updates, clear countdown, rr pointer
    typedef struct {
        logic [63:0] pc;
        logic        tk;
    } ent_t;
    typedef struct {
        logic [63:0] pc;
        int          c;
    } log_t;

    ent_t q[$];
    log_t olog[$];
    bit   m_init = 1'b1;
    int   m_left = 0;
    int   m_rr = 0;
    int   cyc = 0;
    int   clr_total = 0;
    int   first_clr = -1;
    int   last_clr = -1;
    int   ready_busy = 0;

    function automatic int m_grant();
        if (m_init || m_left > 0 || flush || q.size() >= 4) return -1;
        for (int i = 0; i < 2; i++) begin
            int k;
            k = (m_rr + i) % 2;
            if (rv[k]) return k;
        end
        return -1;
    endfunction

    bit         n_run;
    int         n_g;
    logic [1:0] n_er;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_busy", 64'(busy), 1);
            chk("rst_clr_we", 64'(clr_we), 0);
            chk("rst_clr_addr", 64'(clr_addr), 0);
            chk("rst_ready", 64'(rr), 0);
            chk("rst_out_valid", 64'(uo.valid), 0);
            chk("rst_out_pc", uo.pc, 0);
            chk("rst_out_taken", 64'(uo.taken), 0);
        end else begin
            n_run = !m_init && m_left == 0;
            n_g   = m_grant();
            n_er  = (n_g < 0) ? 2'b00 : (2'b01 << n_g);
            chk("busy", 64'(busy), 64'(!n_run));
            chk("clr_we", 64'(clr_we), 64'(m_left > 0));
            if (m_left > 0) chk("clr_addr", 64'(clr_addr), 64'(NROWS - m_left));
            chk("ready", 64'(rr), 64'(n_er));
            chk("out_valid", 64'(uo.valid), 64'(n_run && q.size() > 0));
            if (n_run && q.size() > 0) begin
                chk("out_pc", uo.pc, q[0].pc);
                chk("out_taken", 64'(uo.taken), 64'(q[0].tk));
            end
            if (clr_we) begin
                clr_total++;
                if (first_clr < 0) first_clr = cyc;
                last_clr = cyc;
            end
            if (busy && rr != 2'b00) ready_busy++;
            if (uo.valid && bready) olog.push_back('{uo.pc, cyc});
        end
    end

    int  p_g;
    bit  p_pop;

    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_init = 1'b1;
            m_left = 0;
            m_rr   = 0;
            cyc    = 0;
        end else begin
            cyc++;
            p_g   = m_grant();
            p_pop = !m_init && m_left == 0 && q.size() > 0 && bready;
            if (m_init) begin
                m_init = 1'b0;
                m_left = NROWS;
            end else if (m_left > 0) begin
                m_left = flush ? NROWS : m_left - 1;
            end else if (flush) begin
                m_left = NROWS;
                q.delete();
            end else begin
                if (p_pop) void'(q.pop_front());
                if (p_g >= 0) begin
                    m_rr = (p_g + 1) % 2;
                    if (!dbg) q.push_back('{ru[p_g].pc, ru[p_g].taken});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(int budget, string nm);
        for (int i = 0; i < budget && busy; i++) step();
        chk({nm, "_timeout"}, 64'(busy), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog");
    end

    int base, acc, c0, g0c, leak;

    initial begin
        ru = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // initial sweep
        wait_idle(600, "init");
        chk("init_busy_fall", 64'(cyc), 513);
        chk("init_first_clr", 64'(first_clr), 1);
        chk("init_last_clr", 64'(last_clr), 512);
        chk("init_clr_count", 64'(clr_total), 512);

        // round-robin, both requesters
        bready = 1'b1;
        ru[0].pc = 64'h100; ru[0].taken = 1'b1;
        ru[1].pc = 64'h200; ru[1].taken = 1'b0;
        rv = 2'b11;
        base = olog.size();
        @(negedge clk);
        g0c = cyc;
        chk("rr_grant0", 64'(rr), 2'b01);
        step();
        rv = 2'b10;
        @(negedge clk);
        chk("rr_grant1", 64'(rr), 2'b10);
        step();
        rv = 2'b00;
        repeat (3) step();
        chk("rr_out_cnt", 64'(olog.size() - base), 2);
        if (olog.size() - base >= 2) begin
            chk("rr_out0_pc", olog[base].pc, 64'h100);
            chk("rr_out1_pc", olog[base+1].pc, 64'h200);
            chk("rr_out0_lat", 64'(olog[base].c - g0c), 1);
            chk("rr_out_consec", 64'(olog[base+1].c - olog[base].c), 1);
        end

        // backpressure: 4 accepted, 5th waits
        bready = 1'b0;
        rv = 2'b01;
        ru[0].pc = 64'h300;
        acc = 0;
        base = olog.size();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rr[0]) acc++;
            step();
            ru[0].pc = 64'h300 + 64'(4 * acc);
        end
        chk("bp_accepted", 64'(acc), 4);
        @(negedge clk);
        chk("bp_ready_low", 64'(rr), 0);
        step();
        bready = 1'b1;
        for (int i = 0; i < 20 && acc < 5; i++) begin
            @(negedge clk);
            if (rr[0]) acc++;
            step();
            ru[0].pc = 64'h300 + 64'(4 * acc);
            if (acc == 5) rv = 2'b00;
        end
        rv = 2'b00;
        chk("bp_fifth", 64'(acc), 5);
        repeat (8) step();
        chk("bp_out_cnt", 64'(olog.size() - base), 5);
        if (olog.size() - base >= 5) begin
            for (int i = 0; i < 5; i++)
                chk("bp_out_pc", olog[base+i].pc, 64'h300 + 64'(4 * i));
            chk("bp_drain_consec", 64'(olog[base+3].c - olog[base].c), 3);
        end

        // flush discards 3 buffered updates
        bready = 1'b0;
        rv = 2'b01;
        ru[0].pc = 64'h400;
        acc = 0;
        for (int i = 0; i < 10 && acc < 3; i++) begin
            @(negedge clk);
            if (rr[0]) acc++;
            step();
            ru[0].pc = 64'h400 + 64'(4 * acc);
        end
        rv = 2'b00;
        chk("fl_buffered", 64'(acc), 3);
        base = olog.size();
        c0 = clr_total;
        ready_busy = 0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        bready = 1'b1;
        ru[0].pc = 64'h500;
        ru[1].pc = 64'h504;
        rv = 2'b11;
        wait_idle(600, "fl");
        rv = 2'b00;
        repeat (4) step();
        chk("fl_clears", 64'(clr_total - c0), 512);
        chk("fl_ready_busy", 64'(ready_busy), 0);
        leak = 0;
        for (int i = base; i < olog.size(); i++)
            if (olog[i].pc >= 64'h400 && olog[i].pc <= 64'h408) leak++;
        chk("fl_no_leak", 64'(leak), 0);

        // restart during flush at row 100
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 300 && clr_addr != 9'd100; i++) step();
        chk("rs_reach100", 64'(clr_addr), 100);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("rs_restart_addr", 64'(clr_addr), 0);
        c0 = clr_total;
        wait_idle(600, "rs");
        chk("rs_clears", 64'(clr_total - c0), 512);

        // debug-mode update dropped, next one delivered
        base = olog.size();
        dbg = 1'b1;
        rv = 2'b01;
        ru[0].pc = 64'h600;
        @(negedge clk);
        chk("dbg_grant", 64'(rr), 2'b01);
        step();
        rv = 2'b00;
        dbg = 1'b0;
        repeat (3) step();
        chk("dbg_no_out", 64'(olog.size() - base), 0);
        rv = 2'b01;
        ru[0].pc = 64'h604;
        @(negedge clk);
        chk("dbg_next_grant", 64'(rr), 2'b01);
        step();
        rv = 2'b00;
        repeat (3) step();
        chk("dbg_next_cnt", 64'(olog.size() - base), 1);
        if (olog.size() > base) chk("dbg_next_pc", olog[base].pc, 64'h604);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
